// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: master ids and SramReq_t/SramRsp_t pack/unpack helpers for the Sim_SRAM boundary
package sram_arb_pkg;
  typedef logic MasterId_t;
  localparam MasterId_t MASTER_IF = 1'b0;
  localparam MasterId_t MASTER_LSU = 1'b1;
  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 64;
  typedef struct packed {
    logic valid;
    logic we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_DATA_W/8-1:0] wstrb;
  } SramReq_t;
  typedef struct packed {
    logic valid;
    logic [SRAM_DATA_W-1:0] rdata;
  } SramRsp_t;
  function automatic SramReq_t pack_req(
    input logic valid,
    input logic we,
    input logic [SRAM_ADDR_W-1:0] addr,
    input logic [SRAM_DATA_W-1:0] wdata,
    input logic [SRAM_DATA_W/8-1:0] wstrb
  );
    return '{valid: valid, we: we, addr: addr, wdata: wdata, wstrb: wstrb};
  endfunction
  function automatic logic unpack_rsp_valid(input SramRsp_t r);
    return r.valid;
  endfunction
  function automatic logic [SRAM_DATA_W-1:0] unpack_rsp_rdata(input SramRsp_t r);
    return r.rdata;
  endfunction
endpackage

// File: rtl/sram_arb_tag_fifo.sv
// sram_arb_tag_fifo: 1-bit tag FIFO (clk, nRst, push/din, pop/dout, full, empty) with wrap-bit pointers
module sram_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [DEPTH-1:0] mem;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= push ? wp + (AW+1)'(1) : wp;
      rp <= pop ? rp + (AW+1)'(1) : rp;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin 2-master (M0 fetch, M1 load/store) to Sim_SRAM arbiter with in-order tag routing, oBusy and sticky oErr
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              iM0ReqValid,
  input  logic              iM0ReqWe,
  input  logic [ADDR_W-1:0] iM0ReqAddr,
  input  logic [DATA_W-1:0] iM0ReqWdata,
  input  logic [DATA_W/8-1:0] iM0ReqWstrb,
  output logic              oM0ReqReady,
  output logic              oM0RspValid,
  output logic [DATA_W-1:0] oM0RspRdata,
  input  logic              iM1ReqValid,
  input  logic              iM1ReqWe,
  input  logic [ADDR_W-1:0] iM1ReqAddr,
  input  logic [DATA_W-1:0] iM1ReqWdata,
  input  logic [DATA_W/8-1:0] iM1ReqWstrb,
  output logic              oM1ReqReady,
  output logic              oM1RspValid,
  output logic [DATA_W-1:0] oM1RspRdata,
  output logic              oSramReqValid,
  output logic              oSramReqWe,
  output logic [ADDR_W-1:0] oSramReqAddr,
  output logic [DATA_W-1:0] oSramReqWdata,
  output logic [DATA_W/8-1:0] oSramReqWstrb,
  input  logic              iSramReqReady,
  input  logic              iSramRspValid,
  input  logic [DATA_W-1:0] iSramRspRdata,
  output logic              oBusy,
  output logic              oErr
);
  MasterId_t gnt, rr, head;
  logic full, empty, elig, acc, pop, err;
  assign elig = nRst && iSramReqReady && !full;
  assign gnt = (iM0ReqValid && iM1ReqValid) ? rr : iM1ReqValid;
  assign oSramReqValid = elig && (iM0ReqValid || iM1ReqValid);
  assign acc = oSramReqValid;
  assign oM0ReqReady = acc && gnt == MASTER_IF;
  assign oM1ReqReady = acc && gnt == MASTER_LSU;
  assign oSramReqWe = gnt == MASTER_LSU ? iM1ReqWe : iM0ReqWe;
  assign oSramReqAddr = gnt == MASTER_LSU ? iM1ReqAddr : iM0ReqAddr;
  assign oSramReqWdata = gnt == MASTER_LSU ? iM1ReqWdata : iM0ReqWdata;
  assign oSramReqWstrb = gnt == MASTER_LSU ? iM1ReqWstrb : iM0ReqWstrb;
  // A response with no tag outstanding is dropped and flagged instead of popped.
  assign pop = iSramRspValid && !empty;
  assign oM0RspValid = pop && head == MASTER_IF;
  assign oM1RspValid = pop && head == MASTER_LSU;
  assign oM0RspRdata = iSramRspRdata;
  assign oM1RspRdata = iSramRspRdata;
  assign oBusy = !empty;
  assign oErr = err;
  sram_arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk(clk),
    .nRst(nRst),
    .push(acc),
    .pop(pop),
    .din(gnt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      rr <= MASTER_IF;
      err <= 1'b0;
    end else begin
      rr <= acc ? ~gnt : rr;
      err <= err | (iSramRspValid && empty);
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven per-cycle vectors plus reset/err sequences for sram_arbiter
module tb_sram_arbiter;
  localparam logic [63:0] W0 = 64'h0000_0000_AAAA_0000;
  localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
  logic clk = 1'b0, nRst = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, we1 = 1'b0, srdy = 1'b0, rv = 1'b0;
  logic [31:0] a0 = '0, a1 = '0;
  logic [7:0] s1 = '0;
  logic [63:0] rd = '0;
  logic r0, r1, p0, p1, sv, swe, busy, err;
  logic [63:0] rd0, rd1, swd;
  logic [31:0] sa;
  logic [7:0] ss;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [4:0] c;
    logic [31:0] a0, a1;
    logic [7:0] s1;
    logic [63:0] rd;
    logic [6:0] e;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  sram_arbiter dut (
    .clk(clk), .nRst(nRst),
    .iM0ReqValid(v0), .iM0ReqWe(1'b0), .iM0ReqAddr(a0), .iM0ReqWdata(W0), .iM0ReqWstrb(8'hFF),
    .oM0ReqReady(r0), .oM0RspValid(p0), .oM0RspRdata(rd0),
    .iM1ReqValid(v1), .iM1ReqWe(we1), .iM1ReqAddr(a1), .iM1ReqWdata(W1), .iM1ReqWstrb(s1),
    .oM1ReqReady(r1), .oM1RspValid(p1), .oM1RspRdata(rd1),
    .oSramReqValid(sv), .oSramReqWe(swe), .oSramReqAddr(sa), .oSramReqWdata(swd), .oSramReqWstrb(ss),
    .iSramReqReady(srdy), .iSramRspValid(rv), .iSramRspRdata(rd),
    .oBusy(busy), .oErr(err)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic t(input logic [4:0] c, input logic [31:0] x0, input logic [31:0] x1,
                   input logic [7:0] s, input logic [63:0] d, input logic [6:0] e);
    tv.push_back('{c: c, a0: x0, a1: x1, s1: s, rd: d, e: e});
  endtask
  task automatic drive(input logic [4:0] c);
    {v0, v1, we1, srdy, rv} = c;
  endtask
  // e = {r0, r1, sv, p0, p1, busy, err}
  task automatic check_outs(input string n, input logic [6:0] e);
    chk({n, " r0"}, 64'(r0), 64'(e[6]));
    chk({n, " r1"}, 64'(r1), 64'(e[5]));
    chk({n, " sv"}, 64'(sv), 64'(e[4]));
    chk({n, " p0"}, 64'(p0), 64'(e[3]));
    chk({n, " p1"}, 64'(p1), 64'(e[2]));
    chk({n, " busy"}, 64'(busy), 64'(e[1]));
    chk({n, " err"}, 64'(err), 64'(e[0]));
  endtask
  initial begin
    t(5'b11010, 32'h100, 32'h200, 8'h00, 64'h0, 7'b1010000);
    t(5'b11011, 32'h100, 32'h200, 8'h00, 64'h1, 7'b0111010);
    t(5'b11011, 32'h100, 32'h200, 8'h00, 64'h2, 7'b1010110);
    t(5'b11011, 32'h100, 32'h200, 8'h00, 64'h3, 7'b0111010);
    t(5'b11011, 32'h100, 32'h200, 8'h00, 64'h4, 7'b1010110);
    t(5'b11011, 32'h100, 32'h200, 8'h00, 64'h5, 7'b0111010);
    t(5'b00011, 32'h100, 32'h200, 8'h00, 64'h7, 7'b0000110);
    t(5'b00010, 32'h100, 32'h200, 8'h00, 64'h0, 7'b0000000);
    t(5'b10010, 32'h100, 32'h200, 8'h00, 64'h0, 7'b1010000);
    t(5'b00010, 32'h100, 32'h200, 8'h00, 64'h0, 7'b0000010);
    t(5'b00011, 32'h100, 32'h200, 8'h00, 64'hDEAD_BEEF, 7'b0001010);
    t(5'b01110, 32'h100, 32'h300, 8'h0F, 64'h0, 7'b0110000);
    t(5'b10010, 32'h140, 32'h300, 8'h0F, 64'h0, 7'b1010010);
    t(5'b00011, 32'h140, 32'h300, 8'h0F, 64'h11, 7'b0000110);
    t(5'b00011, 32'h140, 32'h300, 8'h0F, 64'h55, 7'b0001010);
    t(5'b00010, 32'h140, 32'h300, 8'h0F, 64'h0, 7'b0000000);
    t(5'b10010, 32'h400, 32'h380, 8'h00, 64'h0, 7'b1010000);
    t(5'b10010, 32'h404, 32'h380, 8'h00, 64'h0, 7'b1010010);
    t(5'b10010, 32'h408, 32'h380, 8'h00, 64'h0, 7'b1010010);
    t(5'b10010, 32'h40C, 32'h380, 8'h00, 64'h0, 7'b1010010);
    t(5'b10010, 32'h410, 32'h380, 8'h00, 64'h0, 7'b0000010);
    t(5'b10011, 32'h410, 32'h380, 8'h00, 64'h21, 7'b0001010);
    t(5'b01010, 32'h410, 32'h380, 8'h00, 64'h0, 7'b0110010);
    t(5'b00011, 32'h410, 32'h380, 8'h00, 64'hA, 7'b0001010);
    t(5'b00011, 32'h410, 32'h380, 8'h00, 64'hB, 7'b0001010);
    t(5'b00011, 32'h410, 32'h380, 8'h00, 64'hC, 7'b0001010);
    t(5'b00011, 32'h410, 32'h380, 8'h00, 64'hD, 7'b0000110);
    t(5'b00010, 32'h410, 32'h380, 8'h00, 64'h0, 7'b0000000);
    t(5'b00001, 32'h410, 32'h380, 8'h00, 64'hE, 7'b0000000);
    t(5'b00000, 32'h410, 32'h380, 8'h00, 64'h0, 7'b0000001);
    t(5'b00001, 32'h410, 32'h380, 8'h00, 64'hF, 7'b0000001);
    drive(5'b10010);
    #1 check_outs("in_reset", 7'b0000000);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].c);
      a0 = tv[i].a0;
      a1 = tv[i].a1;
      s1 = tv[i].s1;
      rd = tv[i].rd;
      #1 check_outs($sformatf("v%0d", i), tv[i].e);
      if (tv[i].e[4]) begin
        chk($sformatf("v%0d addr", i), 64'(sa), 64'(tv[i].e[5] ? tv[i].a1 : tv[i].a0));
        chk($sformatf("v%0d we", i), 64'(swe), 64'(tv[i].e[5] & tv[i].c[2]));
        chk($sformatf("v%0d strb", i), 64'(ss), 64'(tv[i].e[5] ? tv[i].s1 : 8'hFF));
        chk($sformatf("v%0d wdata", i), swd, tv[i].e[5] ? W1 : W0);
      end
      if (tv[i].e[3] | tv[i].e[2]) begin
        chk($sformatf("v%0d rdata0", i), rd0, tv[i].rd);
        chk($sformatf("v%0d rdata1", i), rd1, tv[i].rd);
      end
      @(negedge clk);
    end
    a0 = 32'h500;
    a1 = 32'h600;
    for (int k = 0; k < 3; k++) begin
      drive(5'b10010);
      #1 chk($sformatf("inflight%0d r0", k), 64'(r0), 64'd1);
      @(negedge clk);
    end
    drive(5'b11010);
    #1 chk("pre_reset busy", 64'(busy), 64'd1);
    chk("pre_reset err", 64'(err), 64'd1);
    nRst = 1'b0;
    #1 check_outs("mid_reset", 7'b0000000);
    @(negedge clk);
    nRst = 1'b1;
    #1 check_outs("post_reset both", 7'b1010000);
    chk("post_reset addr", 64'(sa), 64'h500);
    @(negedge clk);
    drive(5'b01010);
    #1 check_outs("post_reset m1", 7'b0110010);
    chk("post_reset m1 addr", 64'(sa), 64'h600);
    @(negedge clk);
    drive(5'b00000);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
